// File: rtl/move_select_pkg.sv
// Shared widths, state encoding and UCI field layout for the root best-move scanner.
package move_select_pkg;

  localparam int VC_EVAL_WIDTH         = 24;
  localparam int VC_MAX_POSITIONS      = 64;
  localparam int VC_MAX_POSITIONS_LOG2 = $clog2(VC_MAX_POSITIONS);
  localparam int VC_UCI_WIDTH          = 16;

  // UCI word layout: {promotion[3:0], to[5:0], from[5:0]}
  localparam int VC_UCI_FROM_LSB  = 0;
  localparam int VC_UCI_TO_LSB    = 6;
  localparam int VC_UCI_PROMO_LSB = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT       = 3'd1,
    ST_COMPARE    = 3'd2,
    ST_RESULT     = 3'd3,
    ST_CLEAR      = 3'd4,
    ST_CLEAR_WAIT = 3'd5
  } state_e;

  function automatic logic [VC_UCI_WIDTH-1:0] make_uci(input logic [3:0] promo,
                                                      input logic [5:0] to_sq,
                                                      input logic [5:0] from_sq);
    logic [VC_UCI_WIDTH-1:0] w;
    w = '0;
    w[VC_UCI_PROMO_LSB +: 4] = promo;
    w[VC_UCI_TO_LSB +: 6]    = to_sq;
    w[VC_UCI_FROM_LSB +: 6]  = from_sq;
    return w;
  endfunction

endpackage

// File: rtl/move_select_if.sv
// Bundle between all_moves (move RAM + root status), move_select and the result consumer.
interface move_select_if
  import move_select_pkg::*;
#(
  parameter int EVAL_WIDTH         = VC_EVAL_WIDTH,
  parameter int MAX_POSITIONS_LOG2 = VC_MAX_POSITIONS_LOG2,
  parameter int UCI_WIDTH          = VC_UCI_WIDTH
);
  logic                          am_moves_ready;
  logic [MAX_POSITIONS_LOG2-1:0] am_move_count;
  logic                          white_to_move_in;
  logic                          initial_mate;
  logic                          initial_stalemate;
  logic signed [EVAL_WIDTH-1:0]  initial_eval;
  logic signed [EVAL_WIDTH-1:0]  eval_out;
  logic [UCI_WIDTH-1:0]          uci_out;
  logic [MAX_POSITIONS_LOG2-1:0] am_move_index;
  logic                          am_clear_moves;
  logic                          best_valid;
  logic                          best_ack;
  logic [MAX_POSITIONS_LOG2-1:0] best_index;
  logic signed [EVAL_WIDTH-1:0]  best_eval;
  logic [UCI_WIDTH-1:0]          best_uci;
  logic                          best_none;
  logic                          best_mate;
  logic                          best_stalemate;

  modport master (
    output am_moves_ready, am_move_count, white_to_move_in, initial_mate, initial_stalemate,
           initial_eval, eval_out, uci_out, best_ack,
    input  am_move_index, am_clear_moves, best_valid, best_index, best_eval, best_uci,
           best_none, best_mate, best_stalemate
  );

  modport slave (
    input  am_moves_ready, am_move_count, white_to_move_in, initial_mate, initial_stalemate,
           initial_eval, eval_out, uci_out, best_ack,
    output am_move_index, am_clear_moves, best_valid, best_index, best_eval, best_uci,
           best_none, best_mate, best_stalemate
  );
endinterface

// File: rtl/move_select.sv
// Walks the all_moves RAM, keeps the best eval for the side to move and hands the
// winner out behind valid/ack before releasing all_moves with a one-cycle clear.
module move_select
  import move_select_pkg::*;
#(
  parameter int EVAL_WIDTH         = VC_EVAL_WIDTH,
  parameter int MAX_POSITIONS_LOG2 = VC_MAX_POSITIONS_LOG2,
  parameter int UCI_WIDTH          = VC_UCI_WIDTH,
  parameter int RD_LATENCY         = 2
) (
  input  logic         clk,
  input  logic         reset,
  move_select_if.slave bus
);
  localparam int         IW       = MAX_POSITIONS_LOG2;
  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                count_q, count_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic                         white_q, white_d;
  logic                         have_best_q, have_best_d;
  logic [IW-1:0]                best_index_q, best_index_d;
  logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
  logic [UCI_WIDTH-1:0]         best_uci_q, best_uci_d;
  logic                         best_none_q, best_none_d;
  logic                         best_mate_q, best_mate_d;
  logic                         best_stalemate_q, best_stalemate_d;

  logic [IW:0] idx_inc;
  logic        more_moves;
  logic        take_move;

  function automatic logic better(input logic signed [EVAL_WIDTH-1:0] cand,
                                  input logic signed [EVAL_WIDTH-1:0] best,
                                  input logic                         white);
    return white ? (cand > best) : (cand < best);
  endfunction

  // One bit wider than the index so a full list (count = MAX-1) never wraps.
  assign idx_inc    = {1'b0, idx_q} + {{IW{1'b0}}, 1'b1};
  assign more_moves = idx_inc < {1'b0, count_q};
  assign take_move  = !have_best_q || better(bus.eval_out, best_eval_q, white_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (bus.am_moves_ready)
                       state_d = (bus.am_move_count == '0) ? ST_RESULT : ST_WAIT;
      ST_WAIT:       if (cnt_q == LAT_LAST) state_d = ST_COMPARE;
      ST_COMPARE:    state_d = more_moves ? ST_WAIT : ST_RESULT;
      ST_RESULT:     if (bus.best_ack) state_d = ST_CLEAR;
      ST_CLEAR:      state_d = ST_CLEAR_WAIT;
      ST_CLEAR_WAIT: if (!bus.am_moves_ready) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.best_valid     = (state_q == ST_RESULT);
    bus.am_clear_moves = (state_q == ST_CLEAR);
    bus.am_move_index  = idx_q;
    bus.best_index     = best_index_q;
    bus.best_eval      = best_eval_q;
    bus.best_uci       = best_uci_q;
    bus.best_none      = best_none_q;
    bus.best_mate      = best_mate_q;
    bus.best_stalemate = best_stalemate_q;
  end

  // Datapath next-state; the result registers only change at scan start or on a taken move.
  always_comb begin
    idx_d            = idx_q;
    count_d          = count_q;
    cnt_d            = cnt_q;
    white_d          = white_q;
    have_best_d      = have_best_q;
    best_index_d     = best_index_q;
    best_eval_d      = best_eval_q;
    best_uci_d       = best_uci_q;
    best_none_d      = best_none_q;
    best_mate_d      = best_mate_q;
    best_stalemate_d = best_stalemate_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.am_moves_ready) begin
          idx_d   = '0;
          cnt_d   = '0;
          count_d = bus.am_move_count;
          white_d = bus.white_to_move_in;
          if (bus.am_move_count == '0) begin
            best_none_d      = 1'b1;
            best_mate_d      = bus.initial_mate;
            best_stalemate_d = bus.initial_stalemate;
            best_eval_d      = bus.initial_eval;
            best_index_d     = '0;
            best_uci_d       = '0;
          end else begin
            have_best_d      = 1'b0;
            best_none_d      = 1'b0;
            best_mate_d      = 1'b0;
            best_stalemate_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != LAT_LAST) cnt_d = cnt_q + 3'd1;
      end
      ST_COMPARE: begin
        if (take_move) begin
          have_best_d  = 1'b1;
          best_index_d = idx_q;
          best_eval_d  = bus.eval_out;
          best_uci_d   = bus.uci_out;
        end
        if (more_moves) begin
          idx_d = idx_inc[IW-1:0];
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q            <= '0;
      count_q          <= '0;
      cnt_q            <= '0;
      white_q          <= 1'b0;
      have_best_q      <= 1'b0;
      best_index_q     <= '0;
      best_eval_q      <= '0;
      best_uci_q       <= '0;
      best_none_q      <= 1'b0;
      best_mate_q      <= 1'b0;
      best_stalemate_q <= 1'b0;
    end else begin
      idx_q            <= idx_d;
      count_q          <= count_d;
      cnt_q            <= cnt_d;
      white_q          <= white_d;
      have_best_q      <= have_best_d;
      best_index_q     <= best_index_d;
      best_eval_q      <= best_eval_d;
      best_uci_q       <= best_uci_d;
      best_none_q      <= best_none_d;
      best_mate_q      <= best_mate_d;
      best_stalemate_q <= best_stalemate_d;
    end
  end

endmodule

// File: tb/tb_move_select.sv
// Scoreboard bench for move_select: directed scans push expected results, a monitor
// pops and compares on every rising best_valid.
`timescale 1ns/1ps
module tb_move_select;
  import move_select_pkg::*;

  localparam int LAT = 2;
  localparam int EW  = VC_EVAL_WIDTH;
  localparam int IW  = VC_MAX_POSITIONS_LOG2;
  localparam int UW  = VC_UCI_WIDTH;

  typedef struct {
    logic [IW-1:0]         idx;
    logic signed [EW-1:0]  eval;
    logic [UW-1:0]         uci;
    logic                  none;
    logic                  mate;
    logic                  stal;
    int                    rise;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  move_select_if #(.EVAL_WIDTH(EW), .MAX_POSITIONS_LOG2(IW), .UCI_WIDTH(UW)) bus ();

  move_select #(
    .EVAL_WIDTH(EW), .MAX_POSITIONS_LOG2(IW), .UCI_WIDTH(UW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  exp_t sb[$];
  exp_t cur;

  // Move RAM model with a LAT-stage read pipeline.
  logic signed [EW-1:0] ram_eval [VC_MAX_POSITIONS];
  logic [UW-1:0]        ram_uci  [VC_MAX_POSITIONS];
  logic signed [EW-1:0] pe [LAT];
  logic [UW-1:0]        pu [LAT];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pe[0] <= ram_eval[bus.am_move_index];
    pu[0] <= ram_uci[bus.am_move_index];
    for (int i = 1; i < LAT; i++) begin
      pe[i] <= pe[i-1];
      pu[i] <= pu[i-1];
    end
  end
  assign bus.eval_out = pe[LAT-1];
  assign bus.uci_out  = pu[LAT-1];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: one result transaction per rising best_valid.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.best_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("result: idx=%0d eval=%0d uci=%h none=%0b mate=%0b stal=%0b cycle=%0d",
                   bus.best_index, bus.best_eval, bus.best_uci, bus.best_none,
                   bus.best_mate, bus.best_stalemate, cyc);
          check("best_index", bus.best_index, e.idx);
          check("best_eval", bus.best_eval, e.eval);
          check("best_uci", bus.best_uci, e.uci);
          check("best_none", bus.best_none, e.none);
          check("best_mate", bus.best_mate, e.mate);
          check("best_stalemate", bus.best_stalemate, e.stal);
          check("valid_rise_cycle", cyc, e.rise);
        end
      end
      prev_valid = bus.best_valid;
    end
  end

  function automatic logic [UW-1:0] uci_of(input int t, input int i);
    return make_uci(4'(t), 6'(i + 8), 6'(i));
  endfunction

  task automatic start_scan(input int n, input logic white, input logic mate,
                            input logic stal, input logic signed [EW-1:0] ieval,
                            input exp_t e, input logic push);
    @(negedge clk);
    bus.am_move_count     = IW'(n);
    bus.white_to_move_in  = white;
    bus.initial_mate      = mate;
    bus.initial_stalemate = stal;
    bus.initial_eval      = ieval;
    bus.am_moves_ready    = 1'b1;
    e.rise = cyc + 1 + n * (LAT + 1);
    if (push) begin
      cur = e;
      sb.push_back(e);
    end
  endtask

  task automatic finish_scan(input int hold, input int n);
    int t = 0;
    while (!bus.best_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("valid_timeout", bus.best_valid, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.best_valid, 1);
      check("hold_index", bus.best_index, cur.idx);
      check("hold_eval", bus.best_eval, cur.eval);
      check("hold_clear", bus.am_clear_moves, 0);
    end
    bus.best_ack = 1'b1;
    @(negedge clk);
    bus.best_ack = 1'b0;
    check("valid_fall", bus.best_valid, 0);
    check("clear_pulse", bus.am_clear_moves, 1);
    check("data_held", bus.best_eval, cur.eval);
    @(negedge clk);
    check("clear_single", bus.am_clear_moves, 0);
    // Ready is still high: no rescan may start.
    for (int h = 0; h < 8; h++) begin
      @(negedge clk);
      check("no_rescan_valid", bus.best_valid, 0);
      check("no_rescan_index", bus.am_move_index, (n == 0) ? 0 : n - 1);
    end
    bus.am_moves_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int t;
    bus.am_moves_ready = 1'b0; bus.am_move_count = '0; bus.white_to_move_in = 1'b0;
    bus.initial_mate = 1'b0; bus.initial_stalemate = 1'b0; bus.initial_eval = '0;
    bus.best_ack = 1'b0;
    for (int i = 0; i < VC_MAX_POSITIONS; i++) begin
      ram_eval[i] = '0;
      ram_uci[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_valid", bus.best_valid, 0);
    check("rst_clear", bus.am_clear_moves, 0);
    check("rst_move_index", bus.am_move_index, 0);
    check("rst_index", bus.best_index, 0);
    check("rst_eval", bus.best_eval, 0);
    check("rst_uci", bus.best_uci, 0);
    check("rst_none", bus.best_none, 0);
    check("rst_mate_stal", {bus.best_mate, bus.best_stalemate}, 0);
    reset = 1'b0;

    // White {10, 50, -3, 50}: tie on 50 keeps index 1.
    ram_eval[0] = 10; ram_eval[1] = 50; ram_eval[2] = -3; ram_eval[3] = 50;
    for (int i = 0; i < 4; i++) ram_uci[i] = uci_of(1, i);
    e = '{idx: 1, eval: 50, uci: uci_of(1, 1), none: 0, mate: 0, stal: 0, rise: 0};
    start_scan(4, 1'b1, 1'b0, 1'b0, 24'sd0, e, 1'b1);
    finish_scan(0, 4);

    // Black {10, -40, 7}.
    ram_eval[0] = 10; ram_eval[1] = -40; ram_eval[2] = 7;
    for (int i = 0; i < 3; i++) ram_uci[i] = uci_of(2, i);
    e = '{idx: 1, eval: -40, uci: uci_of(2, 1), none: 0, mate: 0, stal: 0, rise: 0};
    start_scan(3, 1'b0, 1'b0, 1'b0, 24'sd0, e, 1'b1);
    finish_scan(0, 3);

    // No legal moves, mate, ack held off 20 cycles.
    e = '{idx: 0, eval: -123, uci: '0, none: 1, mate: 1, stal: 0, rise: 0};
    start_scan(0, 1'b1, 1'b1, 1'b0, -24'sd123, e, 1'b1);
    finish_scan(20, 0);

    // No legal moves, stalemate.
    e = '{idx: 0, eval: 0, uci: '0, none: 1, mate: 0, stal: 1, rise: 0};
    start_scan(0, 1'b0, 1'b0, 1'b1, 24'sd0, e, 1'b1);
    finish_scan(0, 0);

    // Reset during WAIT of move 2 of 5: abort, no clear pulse.
    for (int i = 0; i < 5; i++) begin
      ram_eval[i] = EW'(i * 7);
      ram_uci[i]  = uci_of(3, i);
    end
    start_scan(5, 1'b1, 1'b0, 1'b0, 24'sd0, e, 1'b0);
    t = 0;
    while (bus.am_move_index != IW'(1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_move2", bus.am_move_index, 1);
    reset = 1'b1;
    bus.am_moves_ready = 1'b0;
    @(negedge clk);
    check("abort_valid", bus.best_valid, 0);
    check("abort_clear", bus.am_clear_moves, 0);
    check("abort_move_index", bus.am_move_index, 0);
    check("abort_index", bus.best_index, 0);
    check("abort_eval", bus.best_eval, 0);
    check("abort_flags", {bus.best_none, bus.best_mate, bus.best_stalemate}, 0);
    reset = 1'b0;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      check("post_abort_quiet", {bus.best_valid, bus.am_clear_moves}, 0);
    end

    // White at signed extremes.
    ram_eval[0] = -24'sd8388608; ram_eval[1] = 24'sd8388607;
    ram_eval[2] = -24'sd8388608; ram_eval[3] = 24'sd0;
    for (int i = 0; i < 4; i++) ram_uci[i] = uci_of(4, i);
    e = '{idx: 1, eval: 24'sd8388607, uci: uci_of(4, 1), none: 0, mate: 0, stal: 0, rise: 0};
    start_scan(4, 1'b1, 1'b0, 1'b0, 24'sd0, e, 1'b1);
    finish_scan(0, 4);

    // Black at signed extremes, tie on the minimum keeps index 2.
    ram_eval[0] = 24'sd0; ram_eval[1] = 24'sd8388607;
    ram_eval[2] = -24'sd8388608; ram_eval[3] = -24'sd8388608;
    for (int i = 0; i < 4; i++) ram_uci[i] = uci_of(5, i);
    e = '{idx: 2, eval: -24'sd8388608, uci: uci_of(5, 2), none: 0, mate: 0, stal: 0, rise: 0};
    start_scan(4, 1'b0, 1'b0, 1'b0, 24'sd0, e, 1'b1);
    finish_scan(0, 4);

    // Full list of MAX_POSITIONS-1 moves; index must stop at 62 without wrapping.
    for (int i = 0; i < VC_MAX_POSITIONS; i++) begin
      ram_eval[i] = (i == 40) ? 24'sd5000 : EW'(i * 10);
      ram_uci[i]  = uci_of(6, i);
    end
    e = '{idx: 40, eval: 5000, uci: uci_of(6, 40), none: 0, mate: 0, stal: 0, rise: 0};
    start_scan(63, 1'b1, 1'b0, 1'b0, 24'sd0, e, 1'b1);
    finish_scan(0, 63);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
